// File: rtl/gp_counter.sv
// General-purpose up/down counter with free-run, modulo and one-shot modes,
// registered terminal-event pulses, sticky flags and a compare output.
module gp_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_data,
  input  logic             i_clr,
  input  logic             i_cnt_en,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_top,
  input  logic [WIDTH-1:0] i_cmp,
  input  logic             i_flg_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_ovf_pls,
  output logic             o_unf_pls,
  output logic             o_ovf_flg,
  output logic             o_unf_flg,
  output logic             o_cmp_eq,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             ovf_pls_reg, unf_pls_reg;
  logic             ovf_flg_reg, unf_flg_reg;
  logic             ovf_ev, unf_ev;
  logic             is_modulo, is_oneshot;

  assign is_modulo  = (i_mode == 2'b01);
  assign is_oneshot = (i_mode == 2'b10);

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state_reg   <= ST_RUN;
      cnt_reg     <= '0;
      ovf_pls_reg <= 1'b0;
      unf_pls_reg <= 1'b0;
      ovf_flg_reg <= 1'b0;
      unf_flg_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ovf_pls_reg <= ovf_ev;
      unf_pls_reg <= unf_ev;
      // A same-cycle event wins over the flag clear for its own flag only.
      ovf_flg_reg <= ovf_ev | (ovf_flg_reg & ~i_flg_clr);
      unf_flg_reg <= unf_ev | (unf_flg_reg & ~i_flg_clr);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ovf_ev     = 1'b0;
    unf_ev     = 1'b0;

    if (i_ld) begin
      cnt_next   = i_ld_data;
      state_next = ST_RUN;
    end else if (i_clr) begin
      cnt_next   = '0;
      state_next = ST_RUN;
    end else if (!is_oneshot) begin
      state_next = ST_RUN;
      if (i_cnt_en) begin
        if (i_dir) begin
          if (is_modulo ? (cnt_reg >= i_top) : (cnt_reg == ALL_ONES)) begin
            cnt_next = '0;
            ovf_ev   = 1'b1;
          end else begin
            cnt_next = cnt_reg + ONE;
          end
        end else begin
          if (cnt_reg == '0) begin
            cnt_next = is_modulo ? i_top : ALL_ONES;
            unf_ev   = 1'b1;
          end else begin
            cnt_next = cnt_reg - ONE;
          end
        end
      end
    end else if (state_reg == ST_RUN && i_cnt_en) begin
      // One-shot: terminal step holds the count and parks in DONE.
      if (i_dir && cnt_reg >= i_top) begin
        state_next = ST_DONE;
        ovf_ev     = 1'b1;
      end else if (!i_dir && cnt_reg == '0) begin
        state_next = ST_DONE;
        unf_ev     = 1'b1;
      end else begin
        cnt_next = i_dir ? cnt_reg + ONE : cnt_reg - ONE;
      end
    end
  end

  assign o_cnt     = cnt_reg;
  assign o_ovf_pls = ovf_pls_reg;
  assign o_unf_pls = unf_pls_reg;
  assign o_ovf_flg = ovf_flg_reg;
  assign o_unf_flg = unf_flg_reg;
  assign o_cmp_eq  = (cnt_reg == i_cmp);
  assign o_done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_gp_counter.sv
// Directed self-checking bench for gp_counter (WIDTH=16).
module tb_gp_counter;

  logic        i_sysclk;
  logic        i_sysrst;
  logic        i_ld;
  logic [15:0] i_ld_data;
  logic        i_clr;
  logic        i_cnt_en;
  logic        i_dir;
  logic [1:0]  i_mode;
  logic [15:0] i_top;
  logic [15:0] i_cmp;
  logic        i_flg_clr;
  logic [15:0] o_cnt;
  logic        o_ovf_pls;
  logic        o_unf_pls;
  logic        o_ovf_flg;
  logic        o_unf_flg;
  logic        o_cmp_eq;
  logic        o_done;

  int n_cmp = 0;
  int n_err = 0;
  int pls_seen = 0;

  gp_counter #(.WIDTH(16)) dut (
    .i_sysclk (i_sysclk),
    .i_sysrst (i_sysrst),
    .i_ld     (i_ld),
    .i_ld_data(i_ld_data),
    .i_clr    (i_clr),
    .i_cnt_en (i_cnt_en),
    .i_dir    (i_dir),
    .i_mode   (i_mode),
    .i_top    (i_top),
    .i_cmp    (i_cmp),
    .i_flg_clr(i_flg_clr),
    .o_cnt    (o_cnt),
    .o_ovf_pls(o_ovf_pls),
    .o_unf_pls(o_unf_pls),
    .o_ovf_flg(o_ovf_flg),
    .o_unf_flg(o_unf_flg),
    .o_cmp_eq (o_cmp_eq),
    .o_done   (o_done)
  );

  initial begin
    i_sysclk = 1'b0;
    forever #5 i_sysclk = ~i_sysclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_sysclk);
    #1;
  endtask

  initial begin
    i_sysrst = 1'b1; i_ld = 0; i_ld_data = '0; i_clr = 0; i_cnt_en = 0;
    i_dir = 1; i_mode = 2'b00; i_top = '0; i_cmp = 16'h5555; i_flg_clr = 0;
    step();
    chk("rst_cnt", o_cnt, 0);
    chk("rst_pls", {o_ovf_pls, o_unf_pls}, 0);
    chk("rst_flg", {o_ovf_flg, o_unf_flg}, 0);
    chk("rst_done", o_done, 0);
    i_sysrst = 1'b0;

    // Free-run up across the wrap
    i_ld = 1; i_ld_data = 16'hFFFE; step();
    chk("fr_ld", o_cnt, 16'hFFFE);
    i_ld = 0; i_cnt_en = 1; i_dir = 1;
    step(); chk("fr_up1", o_cnt, 16'hFFFF); chk("fr_up1_pls", o_ovf_pls, 0);
    step(); chk("fr_up2", o_cnt, 16'h0000); chk("fr_up2_pls", o_ovf_pls, 1);
    chk("fr_up2_flg", o_ovf_flg, 1);
    step(); chk("fr_up3", o_cnt, 16'h0001); chk("fr_up3_pls", o_ovf_pls, 0);
    chk("fr_up3_flg", o_ovf_flg, 1);

    // Free-run down from 0
    i_cnt_en = 0; i_ld = 1; i_ld_data = 16'h0000; step();
    i_ld = 0; i_cnt_en = 1; i_dir = 0; step();
    chk("fr_dn", o_cnt, 16'hFFFF); chk("fr_dn_pls", o_unf_pls, 1);
    chk("fr_dn_flg", o_unf_flg, 1);

    // Overflow event with flag clear in the same cycle
    i_dir = 1; i_flg_clr = 1; step();
    chk("fc_cnt", o_cnt, 0);
    chk("fc_ovf_flg", o_ovf_flg, 1); chk("fc_unf_flg", o_unf_flg, 0);
    i_flg_clr = 0; i_cnt_en = 0; step();
    chk("hold_cnt", o_cnt, 0); chk("hold_pls", o_ovf_pls, 0);
    chk("hold_flg", o_ovf_flg, 1);
    i_flg_clr = 1; step(); i_flg_clr = 0;
    chk("flg_clr", {o_ovf_flg, o_unf_flg}, 0);

    // Modulo down from 0 with top 9
    i_mode = 2'b01; i_top = 16'd9; i_clr = 1; step();
    chk("md_clr", o_cnt, 0);
    i_clr = 0; i_dir = 0; i_cnt_en = 1;
    step(); chk("md_dn1", o_cnt, 9); chk("md_dn1_pls", o_unf_pls, 1);
    chk("md_dn1_flg", o_unf_flg, 1);
    step(); chk("md_dn2", o_cnt, 8); chk("md_dn2_pls", o_unf_pls, 0);
    i_cnt_en = 0; i_flg_clr = 1; step(); i_flg_clr = 0;
    chk("md_flgclr", o_unf_flg, 0); chk("md_hold", o_cnt, 8);

    // Modulo above top: up wraps to 0, down decrements
    i_ld = 1; i_ld_data = 16'd15; step(); i_ld = 0;
    i_cnt_en = 1; i_dir = 1; step(); i_cnt_en = 0;
    chk("md_up_hi", o_cnt, 0); chk("md_up_hi_pls", o_ovf_pls, 1);
    i_ld = 1; step(); i_ld = 0;
    i_cnt_en = 1; i_dir = 0; step(); i_cnt_en = 0;
    chk("md_dn_hi", o_cnt, 14); chk("md_dn_hi_pls", o_unf_pls, 0);

    // One-shot up to top 3
    i_mode = 2'b10; i_top = 16'd3; i_clr = 1; step(); i_clr = 0;
    chk("os_clr", o_cnt, 0);
    i_dir = 1; i_cnt_en = 1;
    step(); chk("os_1", o_cnt, 1); pls_seen += o_ovf_pls;
    step(); chk("os_2", o_cnt, 2); pls_seen += o_ovf_pls;
    step(); chk("os_3", o_cnt, 3); pls_seen += o_ovf_pls;
    chk("os_3_done", o_done, 0);
    step(); chk("os_4", o_cnt, 3); chk("os_4_done", o_done, 1); pls_seen += o_ovf_pls;
    step(); chk("os_5", o_cnt, 3); pls_seen += o_ovf_pls;
    step(); chk("os_6", o_cnt, 3); chk("os_6_done", o_done, 1); pls_seen += o_ovf_pls;
    chk("os_pls_count", pls_seen, 1);
    i_cnt_en = 0; i_clr = 1; step(); i_clr = 0;
    chk("os_clr_cnt", o_cnt, 0); chk("os_clr_done", o_done, 0);

    // Load beats clear beats count
    i_mode = 2'b00; i_ld = 1; i_clr = 1; i_cnt_en = 1; i_ld_data = 16'h1234;
    i_cmp = 16'h1234; step();
    i_ld = 0; i_clr = 0; i_cnt_en = 0;
    chk("pri_cnt", o_cnt, 16'h1234);
    chk("pri_pls", {o_ovf_pls, o_unf_pls}, 0);
    chk("cmp_eq_hit", o_cmp_eq, 1);
    i_cmp = 16'h1235; #1;
    chk("cmp_eq_miss", o_cmp_eq, 0);

    // Async reset while parked in DONE
    i_mode = 2'b10; i_top = 16'h00AB; i_ld = 1; i_ld_data = 16'h00AB; step(); i_ld = 0;
    i_cnt_en = 1; i_dir = 1; step(); i_cnt_en = 0;
    chk("ar_pre_cnt", o_cnt, 16'h00AB); chk("ar_pre_done", o_done, 1);
    #2; i_sysrst = 1; #1;
    chk("ar_cnt", o_cnt, 0); chk("ar_done", o_done, 0);
    chk("ar_pls_flg", {o_ovf_pls, o_unf_pls, o_ovf_flg, o_unf_flg}, 0);
    #1; i_sysrst = 0;
    i_cnt_en = 1; step(); i_cnt_en = 0;
    chk("ar_first", o_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
